ap1000_reset_sequencer: RTL
===========================

# ap1000_reset_sequencer

Reset sequencer for the AP1000 clock/reset block. It holds the PLB, OPB and CPU reset domains in reset until the DCM lock indication has been stable. It then releases the domains in a fixed order (PLB, then OPB, then CPU) with programmable gaps between them. It also services software-requested system and CPU-only resets, and re-enters full reset whenever lock is lost.

## Interface
Parameters:
- LOCK_STABLE_CYCLES, 16: consecutive synchronized-lock-high cycles required before sequencing starts (≥1)
- PLB_DLY, 8: cycles from sequencing start to RSTPLB release (≥1)
- OPB_DLY, 8: cycles from RSTPLB release to RSTOPB release (≥1)
- CPU_DLY, 16: cycles from RSTOPB release to RSTCPU release (≥1)
- SW_RST_CYCLES, 32: assertion length of software-requested resets (≥1)
- CNT_W, 8: counter width; must satisfy 2^CNT_W > max of all delay parameters

Ports:
- fpga_plb_clk  in  1  sole clock
- async_fpga_rst_n  in  1  reset, asynchronous, active-low
- dcm_locked  in  1  DCM lock, asynchronous to fpga_plb_clk
- sys_rst_req  in  1  software system-reset request, one-cycle pulse, synchronous
- cpu_rst_req  in  1  software CPU-only reset request, one-cycle pulse, synchronous
- RSTPLB  out  1  PLB domain reset, active-high
- RSTOPB  out  1  OPB domain reset, active-high
- RSTCPU  out  1  CPU reset, active-high
- rst_done  out  1  high only in RUN
- rst_state  out  3  current state encoding, for debug

## Operation
- dcm_locked passes through a 2-flop synchronizer to produce lock_s.
- One CNT_W-bit counter is used. It clears on every state entry.
- States and transitions:
  - WAIT_LOCK: counter increments while lock_s=1 and clears when lock_s=0. When lock_s=1 and cnt==LOCK_STABLE_CYCLES-1, go to DLY_PLB.
  - DLY_PLB: when cnt==PLB_DLY-1, go to DLY_OPB and deassert RSTPLB.
  - DLY_OPB: when cnt==OPB_DLY-1, go to DLY_CPU and deassert RSTOPB.
  - DLY_CPU: when cnt==CPU_DLY-1, go to RUN, deassert RSTCPU and set rst_done.
  - RUN: all resets low.
    - sys_rst_req goes to SYS_HOLD and asserts all three resets.
    - cpu_rst_req goes to CPU_HOLD and asserts RSTCPU only.
  - SYS_HOLD: all resets high. When cnt==SW_RST_CYCLES-1, go to WAIT_LOCK.
  - CPU_HOLD: RSTCPU high, RSTPLB/RSTOPB low. When cnt==SW_RST_CYCLES-1, go to RUN and deassert RSTCPU.
- Lock loss: lock_s=0 in any state other than WAIT_LOCK goes to WAIT_LOCK next cycle. All resets assert and rst_done clears. This has highest priority.
- Priority in RUN: lock loss > sys_rst_req > cpu_rst_req. If both requests arrive in the same cycle, only the system reset is taken.
- Requests arriving outside RUN are dropped and not queued.
- Reset release order is always PLB → OPB → CPU. No state releases CPU while PLB or OPB is held, and no state holds PLB while releasing CPU.

## Timing
- During async_fpga_rst_n=0:
  - RSTPLB=RSTOPB=RSTCPU=1, rst_done=0.
  - State is WAIT_LOCK, counter is 0, synchronizer flops are 0.
  - Asserting async_fpga_rst_n mid-sequence forces this state immediately (asynchronously).
- All outputs are registered and change on the fpga_plb_clk edge that performs the transition.
- Latency from dcm_locked rising (stable) to:
  - RSTPLB low: 2 + LOCK_STABLE_CYCLES + PLB_DLY cycles, ±1 for synchronizer sampling.
  - RSTOPB low: a further OPB_DLY cycles.
  - RSTCPU low and rst_done high: a further CPU_DLY cycles.
- Lock loss: resets assert 3 cycles after dcm_locked falls (2 synchronizer cycles + 1 registered).
- Software requests: resets assert on the cycle after the request pulse and stay high for exactly SW_RST_CYCLES cycles.
- A lock glitch shorter than LOCK_STABLE_CYCLES in WAIT_LOCK restarts the stability count from 0.

## Structure
- Shared package ap1000_rst_pkg holds:
  - State encodings: WAIT_LOCK=0, DLY_PLB=1, DLY_OPB=2, DLY_CPU=3, RUN=4, SYS_HOLD=5, CPU_HOLD=6.
  - Default delay constants.
- Sub-module ap1000_sync2: 2-flop synchronizer with async active-low reset and a 0 reset value, used for dcm_locked.

## Test plan
- Defaults, dcm_locked high from cycle 5 after reset release → RSTPLB falls at ~cycle 31, RSTOPB 8 cycles later, RSTCPU and rst_done 16 cycles after that. rst_state walks 0→1→2→3→4.
- dcm_locked pulses low for 3 cycles at stability count 10 → count restarts. First RSTPLB fall is delayed by the glitch plus 10 cycles.
- RUN, cpu_rst_req pulse → RSTCPU high for exactly 32 cycles while RSTPLB/RSTOPB stay 0. Returns to RUN with rst_done=1 afterwards.
- RUN, sys_rst_req and cpu_rst_req in the same cycle → all three resets high for 32 cycles, then the full WAIT_LOCK sequence replays.
- dcm_locked drops during DLY_OPB → all resets high 3 cycles later, rst_state=0. Relocking replays the full sequence.
- async_fpga_rst_n pulsed low during CPU_HOLD → outputs immediately at reset values. After release the bench sees a clean cold sequence.

Source files
------------

// File: rtl/ap1000_rst_pkg.sv
// AP1000 reset sequencer shared types.
// State encodings and default delay constants.
package ap1000_rst_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      DLY_PLB   = 3'd1,
      DLY_OPB   = 3'd2,
      DLY_CPU   = 3'd3,
      RUN       = 3'd4,
      SYS_HOLD  = 3'd5,
      CPU_HOLD  = 3'd6
   } rst_state_e;

   localparam int unsigned DEF_LOCK_STABLE_CYCLES = 16;
   localparam int unsigned DEF_PLB_DLY            = 8;
   localparam int unsigned DEF_OPB_DLY            = 8;
   localparam int unsigned DEF_CPU_DLY            = 16;
   localparam int unsigned DEF_SW_RST_CYCLES      = 32;
   localparam int unsigned DEF_CNT_W              = 8;

endpackage

// File: rtl/ap1000_sync2.sv
// Two-flop synchronizer, async active-low reset to 0.
// Brings the DCM lock indication into the PLB clock domain.
module ap1000_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/ap1000_reset_sequencer.sv
// AP1000 reset sequencer: lock qualification, ordered PLB/OPB/CPU
// release, software system/CPU resets and lock-loss recovery.
module ap1000_reset_sequencer
   import ap1000_rst_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned PLB_DLY            = DEF_PLB_DLY,
   parameter int unsigned OPB_DLY            = DEF_OPB_DLY,
   parameter int unsigned CPU_DLY            = DEF_CPU_DLY,
   parameter int unsigned SW_RST_CYCLES      = DEF_SW_RST_CYCLES,
   parameter int unsigned CNT_W              = DEF_CNT_W
) (
   input  logic       fpga_plb_clk,
   input  logic       async_fpga_rst_n,
   input  logic       dcm_locked,
   input  logic       sys_rst_req,
   input  logic       cpu_rst_req,
   output logic       RSTPLB,
   output logic       RSTOPB,
   output logic       RSTCPU,
   output logic       rst_done,
   output logic [2:0] rst_state
);

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PLB_LAST  = CNT_W'(PLB_DLY - 1);
   localparam logic [CNT_W-1:0] OPB_LAST  = CNT_W'(OPB_DLY - 1);
   localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DLY - 1);
   localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);

   rst_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             lock_s;

   ap1000_sync2 u_lock_sync (
      .clk   (fpga_plb_clk),
      .rst_n (async_fpga_rst_n),
      .d     (dcm_locked),
      .q     (lock_s)
   );

   assign rst_state = state;

   always_ff @(posedge fpga_plb_clk or negedge async_fpga_rst_n) begin
      if (!async_fpga_rst_n) begin
         state    <= WAIT_LOCK;
         cnt      <= '0;
         RSTPLB   <= 1'b1;
         RSTOPB   <= 1'b1;
         RSTCPU   <= 1'b1;
         rst_done <= 1'b0;
      end else if (!lock_s && state != WAIT_LOCK) begin
         // Lock loss overrides everything, including pending requests.
         state    <= WAIT_LOCK;
         cnt      <= '0;
         RSTPLB   <= 1'b1;
         RSTOPB   <= 1'b1;
         RSTCPU   <= 1'b1;
         rst_done <= 1'b0;
      end else begin
         unique case (state)
            WAIT_LOCK: begin
               if (!lock_s) begin
                  cnt <= '0;
               end else if (cnt == LOCK_LAST) begin
                  state <= DLY_PLB;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DLY_PLB: begin
               if (cnt == PLB_LAST) begin
                  state  <= DLY_OPB;
                  cnt    <= '0;
                  RSTPLB <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DLY_OPB: begin
               if (cnt == OPB_LAST) begin
                  state  <= DLY_CPU;
                  cnt    <= '0;
                  RSTOPB <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DLY_CPU: begin
               if (cnt == CPU_LAST) begin
                  state    <= RUN;
                  cnt      <= '0;
                  RSTCPU   <= 1'b0;
                  rst_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               cnt <= '0;
               if (sys_rst_req) begin
                  state    <= SYS_HOLD;
                  RSTPLB   <= 1'b1;
                  RSTOPB   <= 1'b1;
                  RSTCPU   <= 1'b1;
                  rst_done <= 1'b0;
               end else if (cpu_rst_req) begin
                  state    <= CPU_HOLD;
                  RSTCPU   <= 1'b1;
                  rst_done <= 1'b0;
               end
            end
            SYS_HOLD: begin
               if (cnt == SW_LAST) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CPU_HOLD: begin
               if (cnt == SW_LAST) begin
                  state    <= RUN;
                  cnt      <= '0;
                  RSTCPU   <= 1'b0;
                  rst_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state    <= WAIT_LOCK;
               cnt      <= '0;
               RSTPLB   <= 1'b1;
               RSTOPB   <= 1'b1;
               RSTCPU   <= 1'b1;
               rst_done <= 1'b0;
            end
         endcase
      end
   end

endmodule
